mem_arbiter: RTL

Two-port-to-one memory arbiter for the pipelined RV32I core. It shares the single unified memory port between the instruction-fetch stage (read-only) and the MEM stage (load/store). Arbitration is fixed-priority, data over fetch, with a starvation limit that guarantees fetch progress. An optional watchdog terminates memory transactions that are never acknowledged.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) two-to-one memory arbiter with a fetch starvation limit.
// Define ARB_TIMEOUT_EN to enable the watchdog that terminates unacknowledged transactions.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StGrantIf, StGrantD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_be_q, m_be_d;

  logic        in_grant;
  logic        timeout_hit;
  logic        xact_done;
  logic        grant_d;
  logic [31:0] rdata_sel;

  assign in_grant = (state_q != StIdle);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;

  // Held at zero while idle, so every grant starts counting from zero.
  always_comb begin
    timer_d = timer_q;
    if (!in_grant) begin
      timer_d = 8'd0;
    end else if (!m_ack) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A real ack in the deadline cycle wins over the timeout.
  assign timeout_hit = in_grant && !m_ack && (timer_q == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign xact_done = in_grant && (m_ack || timeout_hit);
  assign rdata_sel = m_ack ? m_rdata : 32'd0;

  always_comb begin
    if_ack   = (state_q == StGrantIf) && xact_done;
    d_ack    = (state_q == StGrantD) && xact_done;
    if_rdata = if_ack ? rdata_sel : 32'd0;
    d_rdata  = d_ack ? rdata_sel : 32'd0;
    if_err   = if_ack && timeout_hit;
    d_err    = d_ack && timeout_hit;
    busy     = in_grant;
  end

  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  assign grant_d = d_req && !(if_req && (starve_q == 4'(STARVE_MAX)));

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    unique case (state_q)
      StIdle: begin
        if (d_req || if_req) begin
          m_req_d = 1'b1;
          if (grant_d) begin
            state_d   = StGrantD;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
            starve_d  = if_req ? starve_q + 4'd1 : 4'd0;
          end else begin
            state_d   = StGrantIf;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = 32'd0;
            m_be_d    = 4'hF;
            starve_d  = 4'd0;
          end
        end
      end
      StGrantIf, StGrantD: begin
        if (xact_done) begin
          state_d   = StIdle;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_addr_d  = 32'd0;
          m_wdata_d = 32'd0;
          m_be_d    = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      starve_q  <= 4'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      m_be_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;

endmodule
